hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage CPU. It detects load-use hazards and drives the

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/hazard_stall_ctrl_if.sv | 19 +
 rtl/hazard_stall_mem_wait_fsm.sv | 85 ++++++++
 rtl/hazard_stall_ctrl.sv | 96 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline-control types and opcode constants
package pipe_ctrl_pkg;

  // Data-memory wait sequencer states
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Opcodes shared with the main decoder
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - data-memory req/ack handshake between controller and memory
interface hazard_stall_ctrl_if;

  logic Mem_req_o;  // registered request from the controller
  logic Mem_ack_i;  // completion from the data memory

  // Controller side
  modport master (
    output Mem_req_o,
    input  Mem_ack_i
  );

  // Data-memory side
  modport slave (
    input  Mem_req_o,
    output Mem_ack_i
  );

endinterface

// File: rtl/hazard_stall_mem_wait_fsm.sv
// rtl/hazard_stall_mem_wait_fsm.sv - RUN/REQ/DONE sequencer for variable-latency data-memory access
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic Mem_access_i,
  input  logic Mem_ack_i,
  output logic Mem_req_o,
  output logic Mem_err_o,
  output logic hold_o
);

  localparam int            TW     = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

  mem_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          req_d;
  logic          err_d;

  // State, timer, request and sticky error registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_RUN;
      timer_q   <= '0;
      Mem_req_o <= 1'b0;
      Mem_err_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      Mem_req_o <= req_d;
      Mem_err_o <= err_d;
    end
  end

  // Next-state logic and the pipeline hold term
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    req_d   = Mem_req_o;
    err_d   = Mem_err_o;
    hold_o  = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Freeze in the same cycle the access shows up; ack is meaningless here
        if (Mem_access_i) begin
          hold_o  = 1'b1;
          state_d = ST_REQ;
          req_d   = 1'b1;
          timer_d = '0;
        end
      end
      ST_REQ: begin
        hold_o = 1'b1;
        if (Mem_ack_i) begin
          // Ack beats a coincident timer expiry
          state_d = ST_DONE;
          req_d   = 1'b0;
        end else if (timer_q == T_LAST) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE: begin
        // One released cycle lets the access leave MEM without re-issuing it
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        req_d   = 1'b0;
      end
    endcase
    // Pipeline stays frozen while reset is asserted
    if (!rst_n_i) begin
      hold_o = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use/branch/memory-wait pipeline sequencing; optional counters via STALL_PERF_CNT_EN
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [REG_AW-1:0]  ID_Rs1_i,
  input  logic [REG_AW-1:0]  ID_Rs2_i,
  input  logic [REG_AW-1:0]  EX_Rd_i,
  input  logic               EX_MemRead_i,
  input  logic               Branch_taken_i,
  input  logic               Mem_access_i,
  hazard_stall_ctrl_if.master mem,
  output logic               PipeHold_o,
  output logic               PCWrite_o,
  output logic               IFIDWrite_o,
  output logic               Stall_o,
  output logic               IFIDFlush_o,
  output logic               Mem_err_o,
  output logic [CNT_W-1:0]   Perf_lu_cnt_o,
  output logic [CNT_W-1:0]   Perf_mem_cnt_o
);

  logic hold;
  logic mem_req;
  logic load_use;

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .Mem_access_i (Mem_access_i),
    .Mem_ack_i    (mem.Mem_ack_i),
    .Mem_req_o    (mem_req),
    .Mem_err_o    (Mem_err_o),
    .hold_o       (hold)
  );

  assign mem.Mem_req_o = mem_req;
  assign PipeHold_o    = hold;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = EX_MemRead_i && (EX_Rd_i != '0) &&
                    ((EX_Rd_i == ID_Rs1_i) || (EX_Rd_i == ID_Rs2_i));

  // Enable priority: memory hold, then load-use bubble, then branch flush
  always_comb begin
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    Stall_o     = 1'b0;
    IFIDFlush_o = 1'b0;
    if (hold) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (load_use) begin
      // Branch in ID is simply retried once the bubble has been inserted
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      Stall_o     = 1'b1;
    end else if (Branch_taken_i) begin
      IFIDFlush_o = 1'b1;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q;
  logic [CNT_W-1:0] mem_cnt_q;

  // Saturating stall-cycle counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (load_use && !hold && (lu_cnt_q != '1)) begin
        lu_cnt_q <= lu_cnt_q + 1'b1;
      end
      if (hold && (mem_cnt_q != '1)) begin
        mem_cnt_q <= mem_cnt_q + 1'b1;
      end
    end
  end

  assign Perf_lu_cnt_o  = lu_cnt_q;
  assign Perf_mem_cnt_o = mem_cnt_q;
`else
  assign Perf_lu_cnt_o  = '0;
  assign Perf_mem_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  // Fields in order: pcw ifw stall flush hold req err
  typedef struct packed {
    logic pcw;
    logic ifw;
    logic stall;
    logic flush;
    logic hold;
    logic req;
    logic err;
  } exp_t;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    exp_t       exp;
  } vec_t;

  localparam exp_t E_NONE  = 7'b1100000;
  localparam exp_t E_STALL = 7'b0010000;
  localparam exp_t E_FLUSH = 7'b1101000;
  localparam exp_t E_HOLD  = 7'b0000100;
  localparam exp_t E_HREQ  = 7'b0000110;
  localparam exp_t E_RST   = 7'b0000100;

`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        mr, br, acc;
  logic        pipe_hold, pc_write, ifid_write, stall, ifid_flush, mem_err;
  logic [31:0] lu_cnt, mem_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  logic err_exp = 1'b0;
  exp_t sb[$];
  vec_t vecs[9];

  hazard_stall_ctrl_if mem_if ();

  hazard_stall_ctrl #(
    .REG_AW      (5),
    .MEM_TIMEOUT (16),
    .CNT_W       (32)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .ID_Rs1_i       (rs1),
    .ID_Rs2_i       (rs2),
    .EX_Rd_i        (rd),
    .EX_MemRead_i   (mr),
    .Branch_taken_i (br),
    .Mem_access_i   (acc),
    .mem            (mem_if.master),
    .PipeHold_o     (pipe_hold),
    .PCWrite_o      (pc_write),
    .IFIDWrite_o    (ifid_write),
    .Stall_o        (stall),
    .IFIDFlush_o    (ifid_flush),
    .Mem_err_o      (mem_err),
    .Perf_lu_cnt_o  (lu_cnt),
    .Perf_mem_cnt_o (mem_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string name);
    exp_t e, a;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      a = {pc_write, ifid_write, stall, ifid_flush, pipe_hold, mem_if.Mem_req_o, mem_err};
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got pcw/ifw/stall/flush/hold/req/err=%b want %b", name, a, e);
      end
    end
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic a, input logic ack, input logic b, input logic m,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input exp_t e, input string name);
    exp_t ex;
    @(posedge clk);
    #1;
    acc = a; mem_if.Mem_ack_i = ack; br = b; mr = m; rs1 = r1; rs2 = r2; rd = d;
    ex = e;
    ex.err = err_exp;
    sb.push_back(ex);
    @(negedge clk);
    check_out(name);
  endtask

  task automatic idle(input string name);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_NONE, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rs1    rs2    rd     mr    br    expected
    vecs[0] = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b0, E_STALL};
    vecs[1] = '{5'd0,  5'd7,  5'd0,  1'b1, 1'b0, E_NONE };
    vecs[2] = '{5'd5,  5'd2,  5'd5,  1'b1, 1'b0, E_STALL};
    vecs[3] = '{5'd5,  5'd5,  5'd5,  1'b0, 1'b0, E_NONE };
    vecs[4] = '{5'd3,  5'd4,  5'd5,  1'b1, 1'b0, E_NONE };
    vecs[5] = '{5'd3,  5'd4,  5'd5,  1'b0, 1'b1, E_FLUSH};
    vecs[6] = '{5'd9,  5'd4,  5'd9,  1'b1, 1'b1, E_STALL};
    vecs[7] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, E_FLUSH};
    vecs[8] = '{5'd31, 5'd1,  5'd31, 1'b1, 1'b0, E_STALL};

    // Reset state with hazard, branch and access inputs all active
    rst_n = 1'b0; acc = 1'b1; mem_if.Mem_ack_i = 1'b1; br = 1'b1; mr = 1'b1;
    rs1 = 5'd5; rs2 = 5'd5; rd = 5'd5;
    #3;
    sb.push_back(E_RST);
    check_out("reset_outputs");
    chk_cnt("reset_lu_cnt", lu_cnt, 32'd0);
    chk_cnt("reset_mem_cnt", mem_cnt, 32'd0);
    @(negedge clk);
    acc = 1'b0; mem_if.Mem_ack_i = 1'b0; br = 1'b0; mr = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    rst_n = 1'b1;

    // Combinational hazard/flush table, one cycle per vector
    foreach (vecs[i]) begin
      cycle(1'b0, 1'b0, vecs[i].br, vecs[i].mr, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].exp, $sformatf("vec%0d", i));
    end
    idle("after_table");
    chk_cnt("lu_cnt_table", lu_cnt, PERF ? 32'd4 : 32'd0);
    chk_cnt("mem_cnt_table", mem_cnt, 32'd0);

    // Ack three cycles after req rises; load-use masked by hold
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HOLD, "t3_access");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HREQ, "t3_req1");
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd5, E_HREQ, "t3_req2_lu_masked");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HREQ, "t3_req3_ack");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_NONE, "t3_done");
    idle("t3_run");
    chk_cnt("lu_cnt_t3", lu_cnt, PERF ? 32'd4 : 32'd0);
    chk_cnt("mem_cnt_t3", mem_cnt, PERF ? 32'd4 : 32'd0);

    // Ack on the last timer cycle: completes without error
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HOLD, "tx_access");
    for (int k = 0; k < 15; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HREQ, $sformatf("tx_req%0d", k));
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HREQ, "tx_ack_at_expiry");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_NONE, "tx_done_no_err");
    idle("tx_run");

    // Timeout: 16 request cycles, then sticky error
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HOLD, "t4_access");
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HREQ, $sformatf("t4_req%0d", k));
    end
    err_exp = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_NONE, "t4_done_err");
    idle("t4_run_err_sticky");
    // Next access still completes; single-cycle ack gives two hold cycles
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HOLD, "t4b_access");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HREQ, "t4b_req_ack");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_NONE, "t4b_done");
    idle("t4b_run");

    // Branch with load-use stalls first, flushes once the hazard clears
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd5, E_STALL, "t5_branch_lu");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd5, E_FLUSH, "t5_branch_flush");
    idle("t5_run");

    // Asynchronous reset in the middle of a request
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HOLD, "t6_access");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HREQ, "t6_req");
    #2;
    rst_n = 1'b0;
    #1;
    err_exp = 1'b0;
    sb.push_back(E_RST);
    check_out("t6_async_drop");
    chk_cnt("t6_lu_cnt", lu_cnt, 32'd0);
    chk_cnt("t6_mem_cnt", mem_cnt, 32'd0);
    @(negedge clk);
    acc = 1'b0;
    rst_n = 1'b1;
    idle("t6_back_in_run");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HOLD, "t6b_access");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_HREQ, "t6b_req_ack");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_NONE, "t6b_done");
    idle("t6b_run");
    chk_cnt("t6b_lu_cnt", lu_cnt, 32'd0);
    chk_cnt("t6b_mem_cnt", mem_cnt, PERF ? 32'd2 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
